// File: rtl/vga_frame_capture_pkg.sv
// Shared timing constants, capture states and the decimated-image address helper
// for the VGA frame capture block.
package vga_frame_capture_pkg;

  localparam int H_ACTIVE     = 640;
  localparam int H_TOTAL      = 800;
  localparam int H_BP         = 48;
  localparam int V_ACTIVE     = 480;
  localparam int V_TOTAL      = 525;
  localparam int V_BP         = 33;
  localparam int DECIM        = 4;
  localparam int DECIM_SHIFT  = $clog2(DECIM);
  localparam int IMAGE_WIDTH  = H_ACTIVE / DECIM;
  localparam int IMAGE_HEIGHT = V_ACTIVE / DECIM;
  localparam int CNT_W        = 10;
  localparam int ADDR_W       = 15;
  localparam int PIX_W        = 12;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2
  } cap_state_e;

  // Row-major address of a full-resolution pixel in the decimated image.
  function automatic logic [ADDR_W-1:0] image_addr(input logic [CNT_W-1:0] x,
                                                   input logic [CNT_W-1:0] y,
                                                   input int width);
    return ADDR_W'(y >> DECIM_SHIFT) * ADDR_W'(width) + ADDR_W'(x >> DECIM_SHIFT);
  endfunction

endpackage

// File: rtl/vga_frame_capture_if.sv
// Incoming VGA pixel stream: 4-bit RGB plus active-low syncs.
interface vga_frame_capture_if;
  logic [3:0] red;
  logic [3:0] green;
  logic [3:0] blue;
  logic       hsync_n;
  logic       vsync_n;

  modport master (output red, green, blue, hsync_n, vsync_n);
  modport slave  (input  red, green, blue, hsync_n, vsync_n);
endinterface

// File: rtl/vga_frame_capture_sync_tracker.sv
// Registers the VGA pins, recovers line/pixel counters from sync rising edges
// and flags line or frame periods that disagree with the nominal timing.
module vga_sync_tracker
  import vga_frame_capture_pkg::*;
#(
  parameter int H_ACTIVE_P = H_ACTIVE,
  parameter int H_TOTAL_P  = H_TOTAL,
  parameter int H_BP_P     = H_BP,
  parameter int V_ACTIVE_P = V_ACTIVE,
  parameter int V_TOTAL_P  = V_TOTAL,
  parameter int V_BP_P     = V_BP
) (
  input  logic               clk_i,
  input  logic               rst_i,
  vga_frame_capture_if.slave vga_i,
  output logic [PIX_W-1:0]   pix_o,
  output logic               v_rise_o,
  output logic               visible_o,
  output logic [CNT_W-1:0]   x_o,
  output logic [CNT_W-1:0]   y_o,
  output logic               timing_err_o
);

  localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOTAL_P - 1);
  localparam logic [CNT_W-1:0] H_LIMIT = CNT_W'(H_TOTAL_P);
  localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_TOTAL_P - 1);
  localparam logic [CNT_W-1:0] H_START = CNT_W'(H_BP_P);
  localparam logic [CNT_W-1:0] H_END   = CNT_W'(H_BP_P + H_ACTIVE_P);
  localparam logic [CNT_W-1:0] V_START = CNT_W'(V_BP_P);
  localparam logic [CNT_W-1:0] V_END   = CNT_W'(V_BP_P + V_ACTIVE_P);

  logic [PIX_W-1:0] pix_q;
  logic             hs_q, hs_qq, vs_q, vs_qq;
  logic [CNT_W-1:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic             h_lock_q, h_lock_d, v_lock_q, v_lock_d;
  logic             h_rise_s, v_rise_s, h_err_s, v_err_s;

  // h_cnt_d/v_cnt_d are the coordinates of the pixel currently held in pix_q.
  always_comb begin
    h_rise_s = hs_q & ~hs_qq;
    v_rise_s = vs_q & ~vs_qq;
    h_cnt_d  = h_rise_s ? {CNT_W{1'b0}} : h_cnt_q + CNT_W'(1);
    if (v_rise_s) begin
      v_cnt_d = {CNT_W{1'b0}};
    end else if (h_rise_s) begin
      v_cnt_d = v_cnt_q + CNT_W'(1);
    end else begin
      v_cnt_d = v_cnt_q;
    end
    h_lock_d = h_lock_q | h_rise_s;
    v_lock_d = v_lock_q | v_rise_s;
    h_err_s  = h_lock_q & (h_rise_s ? (h_cnt_q != H_LAST) : (h_cnt_d == H_LIMIT));
    v_err_s  = v_lock_q & v_rise_s & (v_cnt_q != V_LAST);
  end

  // Syncs reset to their idle (high) level so reset release creates no false edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pix_q    <= {PIX_W{1'b0}};
      hs_q     <= 1'b1;
      hs_qq    <= 1'b1;
      vs_q     <= 1'b1;
      vs_qq    <= 1'b1;
      h_cnt_q  <= {CNT_W{1'b0}};
      v_cnt_q  <= {CNT_W{1'b0}};
      h_lock_q <= 1'b0;
      v_lock_q <= 1'b0;
    end else begin
      pix_q    <= {vga_i.red, vga_i.green, vga_i.blue};
      hs_q     <= vga_i.hsync_n;
      hs_qq    <= hs_q;
      vs_q     <= vga_i.vsync_n;
      vs_qq    <= vs_q;
      h_cnt_q  <= h_cnt_d;
      v_cnt_q  <= v_cnt_d;
      h_lock_q <= h_lock_d;
      v_lock_q <= v_lock_d;
    end
  end

  assign pix_o        = pix_q;
  assign v_rise_o     = v_rise_s;
  assign timing_err_o = h_err_s | v_err_s;
  assign visible_o    = (h_cnt_d >= H_START) && (h_cnt_d < H_END) &&
                        (v_cnt_d >= V_START) && (v_cnt_d < V_END);
  assign x_o          = h_cnt_d - H_START;
  assign y_o          = v_cnt_d - V_START;

endmodule

// File: rtl/vga_frame_capture.sv
// VGA receiver: decimates the visible area and writes one frame-buffer word per
// kept pixel, under an IDLE/ARMED/CAPTURE control FSM.
module vga_frame_capture
  import vga_frame_capture_pkg::*;
#(
  parameter int H_ACTIVE_P = H_ACTIVE,
  parameter int H_TOTAL_P  = H_TOTAL,
  parameter int H_BP_P     = H_BP,
  parameter int V_ACTIVE_P = V_ACTIVE,
  parameter int V_TOTAL_P  = V_TOTAL,
  parameter int V_BP_P     = V_BP
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               capture_en_i,
  input  logic               continuous_i,
  vga_frame_capture_if.slave vga_i,
  output logic               wr_en_o,
  output logic [ADDR_W-1:0]  wr_addr_o,
  output logic [PIX_W-1:0]   wr_data_o,
  output logic               busy_o,
  output logic               frame_done_o,
  output logic               sync_err_o
);

  localparam int               IMG_W     = H_ACTIVE_P / DECIM;
  localparam int               IMG_H     = V_ACTIVE_P / DECIM;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_W * IMG_H - 1);
  localparam logic [CNT_W-1:0]  SUB_MASK  = CNT_W'(DECIM - 1);

  logic [PIX_W-1:0]  pix_s;
  logic              v_rise_s, visible_s, timing_err_s, kept_s;
  logic [CNT_W-1:0]  x_s, y_s;
  logic [ADDR_W-1:0] addr_s;

  cap_state_e        state_q, state_d;
  logic              wr_en_q, wr_en_d, busy_q, busy_d;
  logic              done_q, done_d, err_q, err_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [PIX_W-1:0]  wr_data_q, wr_data_d;

  vga_sync_tracker #(
    .H_ACTIVE_P (H_ACTIVE_P),
    .H_TOTAL_P  (H_TOTAL_P),
    .H_BP_P     (H_BP_P),
    .V_ACTIVE_P (V_ACTIVE_P),
    .V_TOTAL_P  (V_TOTAL_P),
    .V_BP_P     (V_BP_P)
  ) u_tracker (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .vga_i        (vga_i),
    .pix_o        (pix_s),
    .v_rise_o     (v_rise_s),
    .visible_o    (visible_s),
    .x_o          (x_s),
    .y_o          (y_s),
    .timing_err_o (timing_err_s)
  );

  assign kept_s = visible_s && ((x_s & SUB_MASK) == {CNT_W{1'b0}}) &&
                  ((y_s & SUB_MASK) == {CNT_W{1'b0}});
  assign addr_s = image_addr(x_s, y_s, IMG_W);

  // Capture control; a timing error abandons the frame and waits for the next vsync.
  always_comb begin
    state_d   = state_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    err_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (capture_en_i) state_d = ARMED;
        else              state_d = IDLE;
      end
      ARMED: begin
        if (!capture_en_i) begin
          state_d = IDLE;
        end else if (timing_err_s) begin
          err_d   = 1'b1;
          state_d = ARMED;
        end else if (v_rise_s) begin
          state_d = CAPTURE;
        end else begin
          state_d = ARMED;
        end
      end
      CAPTURE: begin
        if (timing_err_s) begin
          err_d   = 1'b1;
          state_d = ARMED;
        end else if (kept_s) begin
          wr_en_d   = 1'b1;
          wr_addr_d = addr_s;
          wr_data_d = pix_s;
          if (addr_s == LAST_ADDR) state_d = (continuous_i && capture_en_i) ? ARMED : IDLE;
          else                     state_d = CAPTURE;
        end else begin
          state_d = CAPTURE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    done_d = wr_en_q && (wr_addr_q == LAST_ADDR);
  end

  // State and output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      wr_en_q   <= 1'b0;
      wr_addr_q <= {ADDR_W{1'b0}};
      wr_data_q <= {PIX_W{1'b0}};
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign wr_en_o      = wr_en_q;
  assign wr_addr_o    = wr_addr_q;
  assign wr_data_o    = wr_data_q;
  assign busy_o       = busy_q;
  assign frame_done_o = done_q;
  assign sync_err_o   = err_q;

endmodule
